// File: rtl/binconv_window_gen.sv
// binconv_window_gen: turns a raster stream of D-bit binary pixels into FH x FW x D conv windows.
// Build option: define WINGEN_STRIDE2_EN to emit only windows whose top-left row and col are even.
module binconv_window_gen #(
  parameter int D     = 512,
  parameter int FH    = 3,
  parameter int FW    = 3,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  localparam int WIN_WIDTH = D * FH * FW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [D-1:0]         pixel_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIN_WIDTH-1:0] out_fmap,
  output logic                 out_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_EMIT = CW'(FW - 1);
  localparam logic [RW-1:0] ROW_RUN  = RW'(FH - 1);
`ifdef WINGEN_STRIDE2_EN
  localparam logic [CW-1:0] LAST_COL = CW'(((IMG_W - FW) / 2) * 2 + FW - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(((IMG_H - FH) / 2) * 2 + FH - 1);
  localparam logic COL_PAR = ((FW - 1) % 2) == 1;
  localparam logic ROW_PAR = ((FH - 1) % 2) == 1;
`else
  localparam logic [CW-1:0] LAST_COL = COL_MAX;
  localparam logic [RW-1:0] LAST_ROW = ROW_MAX;
`endif

  typedef enum logic {FILL, RUN} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          emit;
  logic          last_hit;
  logic          col_ok;
  logic          row_ok;

  logic [D-1:0]         new_col  [FH];
  logic [D-1:0]         win_next [FH][FW];
  logic [WIN_WIDTH-1:0] win_flat;

  // HOLD is not a stored state: it is the combinational stall out_valid && !out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (FH > 1) state <= FILL;
      else        state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (accept && col == COL_MAX) begin
      if (row == ROW_MAX) begin
        if (FH > 1) state_next = FILL;
        else        state_next = RUN;
      end else if (row + RW'(1) == ROW_RUN) begin
        state_next = RUN;
      end
    end
  end

  always_comb begin
    in_ready = !out_valid || out_ready;
    accept   = in_valid && in_ready;
    col_ok   = col >= COL_EMIT;
    row_ok   = 1'b1;
`ifdef WINGEN_STRIDE2_EN
    col_ok   = (col >= COL_EMIT) && (col[0] == COL_PAR);
    row_ok   = row[0] == ROW_PAR;
`endif
    emit     = accept && (state == RUN) && col_ok && row_ok;
    last_hit = (row == LAST_ROW) && (col == LAST_COL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffer 0 holds the oldest row; each accepted pixel pushes its column up by one row.
  if (FH > 1) begin : g_lines
    logic [D-1:0] line_buf [FH-1][IMG_W];

    always_ff @(posedge clk) begin
      if (accept) begin
        for (int i = 0; i < FH - 2; i++) line_buf[i][col] <= line_buf[i+1][col];
        line_buf[FH-2][col] <= pixel_in;
      end
    end

    always_comb begin
      for (int i = 0; i < FH - 1; i++) new_col[i] = line_buf[i][col];
      new_col[FH-1] = pixel_in;
    end
  end else begin : g_no_lines
    always_comb new_col[0] = pixel_in;
  end

  // Previous FW-1 columns of the current row; stale columns from a row wrap are never emitted.
  if (FW > 1) begin : g_hist
    logic [D-1:0] hist [FH][FW-1];

    always_ff @(posedge clk) begin
      if (accept) begin
        for (int r = 0; r < FH; r++) begin
          for (int c = 0; c < FW - 2; c++) hist[r][c] <= hist[r][c+1];
          hist[r][FW-2] <= new_col[r];
        end
      end
    end

    always_comb begin
      for (int r = 0; r < FH; r++) begin
        for (int c = 0; c < FW - 1; c++) win_next[r][c] = hist[r][c];
        win_next[r][FW-1] = new_col[r];
      end
    end
  end else begin : g_no_hist
    always_comb begin
      for (int r = 0; r < FH; r++) win_next[r][0] = new_col[r];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < FH; r++) begin
      for (int c = 0; c < FW; c++) win_flat[(r*FW+c)*D +: D] = win_next[r][c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_fmap  <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_last  <= last_hit;
      out_fmap  <= win_flat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_binconv_window_gen.sv
// tb_binconv_window_gen: random-data frames with random handshakes, scored against a whole-frame window model.
module tb_binconv_window_gen;

  localparam int D    = 4;
  localparam int FH   = 3;
  localparam int FW   = 3;
  localparam int W    = 5;
  localparam int H    = 5;
  localparam int WIN  = D * FH * FW;
  localparam int NPIX = W * H;
`ifdef WINGEN_STRIDE2_EN
  localparam int STRIDE = 2;
`else
  localparam int STRIDE = 1;
`endif
  localparam int NWIN   = ((H - FH) / STRIDE + 1) * ((W - FW) / STRIDE + 1);
  localparam int BUDGET = 3000;

  typedef logic [D-1:0] pix_t;
  typedef struct {
    logic [WIN-1:0] fmap;
    logic           last;
    int             idx;
  } win_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [D-1:0]   pixel_in;
  logic           out_valid;
  logic           out_ready;
  logic [WIN-1:0] out_fmap;
  logic           out_last;

  pix_t src_q [$];
  win_t exp_q [$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   sent_base = 0;
  int   accepted_total = 0;
  int   accepted_here = 0;
  int   windows_seen = 0;
  logic prev_valid = 1'b0;

  binconv_window_gen #(.D(D), .FH(FH), .FW(FW), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pixel_in  (pixel_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fmap  (out_fmap),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: every window of a frame is cut directly from the whole image array.
  task automatic add_frame(input bit directed);
    pix_t img [H][W];
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        img[r][c] = directed ? pix_t'((r * W + c) % 16) : pix_t'($urandom);
        src_q.push_back(img[r][c]);
      end
    end
    for (int tr = 0; tr <= H - FH; tr += STRIDE) begin
      for (int tc = 0; tc <= W - FW; tc += STRIDE) begin
        win_t w;
        w.fmap = '0;
        for (int r = 0; r < FH; r++)
          for (int c = 0; c < FW; c++) w.fmap[(r*FW+c)*D +: D] = img[tr+r][tc+c];
        w.last = (tr + STRIDE > H - FH) && (tc + STRIDE > W - FW);
        w.idx  = sent_base + (tr + FH - 1) * W + tc + FW - 1;
        exp_q.push_back(w);
      end
    end
    sent_base += NPIX;
  endtask

  task automatic check_output();
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL spurious_window: observed out_valid=1 expected no window pending");
      end else begin
        if (!prev_valid) check("latency_pixels_accepted", 64'(accepted_total), 64'(exp_q[0].idx + 1));
        check("out_fmap", 64'(out_fmap), 64'(exp_q[0].fmap));
        check("out_last", 64'(out_last), 64'(exp_q[0].last));
        if (!out_ready) begin
          check("in_ready_stalled", 64'(in_ready), 64'(0));
        end else begin
          void'(exp_q.pop_front());
          windows_seen++;
        end
      end
    end else begin
      check("in_ready_idle", 64'(in_ready), 64'(1));
    end
    if (in_valid && in_ready) begin
      void'(src_q.pop_front());
      accepted_total++;
      accepted_here++;
    end
    prev_valid = out_valid;
  endtask

  task automatic apply_stimulus(input int valid_pct, input int ready_pct, input int hold_cycles,
                                input int stop_after);
    int cycles = 0;
    int held = 0;
    accepted_here = 0;
    while (1) begin
      if (cycles >= BUDGET) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL timeout: observed %0d windows pending expected 0", exp_q.size());
        break;
      end
      if (stop_after < 0 && src_q.size() == 0 && exp_q.size() == 0) break;
      if (stop_after >= 0 && accepted_here >= stop_after) break;
      @(posedge clk);
      #1;
      in_valid  = (src_q.size() > 0) && (int'($urandom_range(99)) < valid_pct);
      pixel_in  = (src_q.size() > 0) ? src_q[0] : '0;
      out_ready = (held < hold_cycles) ? 1'b0 : (int'($urandom_range(99)) < ready_pct);
      @(negedge clk);
      if (out_valid && !out_ready && held < hold_cycles) held++;
      check_output();
      cycles++;
    end
  endtask

  task automatic finish_run(input int expected_windows);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("idle_out_valid", 64'(out_valid), 64'(0));
    check("window_count", 64'(windows_seen), 64'(expected_windows));
    prev_valid = out_valid;
    windows_seen = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_last", 64'(out_last), 64'(0));
    check("reset_out_fmap", 64'(out_fmap), 64'(0));
    src_q.delete();
    exp_q.delete();
    sent_base    = accepted_total;
    prev_valid   = 1'b0;
    windows_seen = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pixel_in  = '0;
    do_reset();

    // Directed frame, no back-pressure.
    add_frame(1'b1);
    apply_stimulus(100, 100, 0, -1);
    finish_run(NWIN);

    // Same frame with the first window held for four cycles.
    add_frame(1'b1);
    apply_stimulus(100, 100, 4, -1);
    finish_run(NWIN);

    // Two identical frames back-to-back.
    add_frame(1'b1);
    add_frame(1'b1);
    apply_stimulus(100, 100, 0, -1);
    finish_run(2 * NWIN);

    // Random data with random gaps on both sides.
    add_frame(1'b0);
    add_frame(1'b0);
    add_frame(1'b0);
    apply_stimulus(70, 60, 0, -1);
    finish_run(3 * NWIN);

    // Reset after seven pixels, then a fresh frame.
    add_frame(1'b0);
    apply_stimulus(100, 100, 0, 7);
    do_reset();
    add_frame(1'b0);
    apply_stimulus(100, 100, 0, -1);
    finish_run(NWIN);

    // Reset while a window is pending under back-pressure.
    add_frame(1'b0);
    apply_stimulus(100, 0, 0, 13);
    do_reset();
    add_frame(1'b1);
    apply_stimulus(80, 70, 0, -1);
    finish_run(NWIN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
